// File: rtl/sar_search_4bit_pkg.sv
// Shared definitions for the 4-bit successive-approximation search.
// Contents:
//   WIDTH       - width of the trial value / result
//   ST_*        - FSM state encodings (IDLE, TEST, DONE)
//   one_flag()  - true when exactly one comparator flag is asserted
package sar_search_4bit_pkg;

    localparam int WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TEST = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic one_flag(input logic gt, input logic lt, input logic eq);
        return ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) || ({gt, lt, eq} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search_4bit.sv
// Bit-trial search of a 4-bit value against an external combinational
// comparator. The trial value is presented on guess; the comparator flags for
// that guess are sampled on the following clock edge.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   begin a search (honoured only in IDLE)
//   cmp_greater  in   target > guess
//   cmp_less     in   target < guess
//   cmp_equal    in   target == guess
//   guess        out  registered trial value (comparator B operand)
//   busy         out  search in progress
//   done         out  one-cycle pulse, result/steps/err valid
//   result       out  search outcome, held until the next accepted start
//   steps        out  comparisons used (1-4), held with result
//   err          out  search ended on an illegal flag combination
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs from the last search held
// TEST  | one comparison per cycle on the current guess
// DONE  | done pulse high for this single cycle, then back to IDLE
module sar_search_4bit
    import sar_search_4bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_greater,
    input  logic             cmp_less,
    input  logic             cmp_equal,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       steps,
    output logic             err
);

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] next_guess;

    // trial: current guess with the bit under test resolved by the comparator.
    // next_guess: trial with the next lower bit set; only used when idx > 0.
    always_comb begin
        trial = guess;
        if (cmp_less) begin
            trial[idx] = 1'b0;
        end
        next_guess = trial;
        next_guess[idx - 2'd1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= 2'd3;
            cnt    <= 3'd0;
            guess  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            steps  <= 3'd0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        guess <= 4'b1000;
                        idx   <= 2'd3;
                        cnt   <= 3'd1;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= ST_TEST;
                    end
                end
                ST_TEST: begin
                    if (!one_flag(cmp_greater, cmp_less, cmp_equal)) begin
                        err    <= 1'b1;
                        result <= guess;
                        steps  <= cnt;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (cmp_equal) begin
                        result <= guess;
                        steps  <= cnt;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (idx == 2'd0) begin
                        guess  <= trial;
                        result <= trial;
                        steps  <= cnt;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        guess <= next_guess;
                        idx   <= idx - 2'd1;
                        cnt   <= cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    // start here is deliberately not looked at
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_search_4bit.md
SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cmp_greater  input  1  external comparator flag: target > guess.
REQ-006 cmp_less  input  1  external comparator flag: target < guess.
REQ-007 cmp_equal  input  1  external comparator flag: target == guess.
REQ-008 guess  output  4  registered trial value driven to the comparator B operand.
REQ-009 busy  output  1  high while a search is in progress.
REQ-010 done  output  1  one-cycle pulse when result is valid.
REQ-011 result  output  4  search outcome, held from done until the next accepted start.
REQ-012 steps  output  3  number of comparisons used (1-4), held with result.
REQ-013 err  output  1  set with done when an illegal flag combination ended the search.

Function
REQ-014 The comparator SHALL be external and combinational; flags for a guess SHALL be sampled on the edge after that guess is registered.
REQ-015 The states SHALL be IDLE, TEST and DONE.
REQ-016 IDLE: start=1 -> guess=4'b1000, bit index=3, step count=1, busy=1, go to TEST; start=0 -> stay, guess holds.
REQ-017 TEST, exactly one flag high:
- cmp_equal -> result=guess, go to DONE.
- cmp_less -> clear guess[index].
- cmp_greater -> keep guess[index].
REQ-018 TEST, non-equal, index>0: set guess[index-1], decrement index, increment step count, stay in TEST.
REQ-019 TEST, non-equal, index=0: result=adjusted guess, go to DONE.
REQ-020 TEST, zero or more than one flag high: err=1, result=current guess, go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, busy=0, steps=comparison count, then IDLE.
REQ-022 Latency from accepted start to done SHALL be (steps+1) cycles; maximum 5.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 err SHALL clear on the next accepted start; result and steps SHALL hold until then.
REQ-025 start in IDLE on the cycle after done SHALL be accepted normally; back-to-back searches need no idle gap.

Reset
REQ-026 rst_n=0 at any clock edge SHALL force IDLE: guess=0, busy=0, done=0, result=0, steps=0, err=0, index=3.
REQ-027 Reset mid-search SHALL abort without a done pulse; the first start after reset release SHALL begin a fresh search.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, TEST, DONE) and the width constant 4.
REQ-029 No sub-module is needed; the bit-trial datapath and FSM SHALL live in this module, and the comparator SHALL stay outside as the flag source.

Verification
REQ-030 Bench models the comparator against target T.
- T=8, start -> guess 8, equal at first sample -> done at cycle 2, result=8, steps=1, err=0.
- T=5 -> guesses 8,4,6,5 -> result=5, steps=4, done at cycle 5.
- T=0 -> guesses 8,4,2,1, all less -> result=0, steps=4, err=0.
- T=15 -> guesses 8,12,14,15 -> result=15, steps=4.
- Illegal flags on the second sample (all flags 0, T=3) -> done, err=1, result=4, steps=2.
- Reset asserted during the third comparison -> no done pulse, all outputs 0.
- start pulsed while busy -> ignored.
- start on the cycle after done -> new search accepted, err cleared.
